// File: rtl/vc_dir_alloc.sv
// Direction allocator for a VC x direction ownership grid.
// Each VC asks for one output direction. Every free direction picks one
// eligible requester by its own round-robin pointer. The winner's claim bit
// is held until the direction is released. The claim array drives the
// downstream per-(vc,dir) state flops as their set/clear control.

module vc_dir_alloc_chk #(
    parameter int NUM_VC  = 4,
    parameter int NUM_DIR = 12
) (
    input logic                      clock,
    input logic                      reset_n,
    input logic [NUM_VC*NUM_DIR-1:0] claim,
    input logic [NUM_DIR-1:0]        dir_busy
);
    for (genvar d = 0; d < NUM_DIR; d++) begin : g_col
        logic [NUM_VC-1:0] col_s;
        for (genvar v = 0; v < NUM_VC; v++) begin : g_bit
            assign col_s[v] = claim[v*NUM_DIR+d];
        end
        // A direction has at most one owner, and busy mirrors its column
        a_col: assert property (@(posedge clock) disable iff (!reset_n)
            $onehot0(col_s) && (dir_busy[d] == (|col_s)));
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_row
        // A VC owns at most one direction
        a_row: assert property (@(posedge clock) disable iff (!reset_n)
            $onehot0(claim[v*NUM_DIR +: NUM_DIR]));
    end
endmodule

module vc_dir_alloc #(
    parameter int NUM_VC  = 4,
    parameter int NUM_DIR = 12,
    parameter int DIR_W   = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_VC-1:0]         req_vc,
    input  logic [NUM_VC*DIR_W-1:0]   req_dir,
    input  logic [NUM_DIR-1:0]        release_dir,
    output logic [NUM_VC-1:0]         grant,
    output logic [NUM_VC*NUM_DIR-1:0] claim,
    output logic [NUM_DIR-1:0]        dir_busy,
    output logic                      bad_dir
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic [NUM_VC*NUM_DIR-1:0] claim_r;
    logic [NUM_VC*NUM_DIR-1:0] claim_nxt_s;
    logic [NUM_VC*NUM_DIR-1:0] win_s;
    logic [NUM_DIR-1:0]        busy_r;
    logic [NUM_DIR-1:0]        busy_nxt_s;
    logic [NUM_DIR-1:0]        found_s;
    logic [NUM_VC-1:0]         grant_r;
    logic [NUM_VC-1:0]         grant_s;
    logic [NUM_VC-1:0]         owns_s;
    logic                      bad_r;
    logic                      bad_s;
    logic [VC_W-1:0]           rr_ptr_r [NUM_DIR];
    logic [VC_W-1:0]           rr_nxt_s [NUM_DIR];
    int                        vi_s;

    // A VC may take direction d only if it asks for d, owns nothing, and d is free
    function automatic logic is_elig(input logic rv, input logic [DIR_W-1:0] rd,
                                     input logic owns, input logic busy, input int d);
        return rv && !owns && !busy && (int'(rd) == d);
    endfunction

    // Per-VC ownership and out-of-range direction detection (owners are ignored)
    always_comb begin
        owns_s = '0;
        bad_s  = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            owns_s[v] = |claim_r[v*NUM_DIR +: NUM_DIR];
            if (req_vc[v] && !owns_s[v] && (int'(req_dir[v*DIR_W +: DIR_W]) >= NUM_DIR)) begin
                bad_s = 1'b1;
            end else begin
                bad_s = bad_s;
            end
        end
    end

    // Per-direction round-robin: search upward from rr_ptr, first eligible VC wins
    always_comb begin
        win_s   = '0;
        grant_s = '0;
        found_s = '0;
        vi_s    = 0;
        for (int d = 0; d < NUM_DIR; d++) begin
            rr_nxt_s[d] = rr_ptr_r[d];
        end
        for (int d = 0; d < NUM_DIR; d++) begin
            for (int k = 0; k < NUM_VC; k++) begin
                vi_s = (int'(rr_ptr_r[d]) + k) % NUM_VC;
                if (!found_s[d] && is_elig(req_vc[vi_s], req_dir[vi_s*DIR_W +: DIR_W],
                                           owns_s[vi_s], busy_r[d], d)) begin
                    found_s[d]              = 1'b1;
                    win_s[vi_s*NUM_DIR + d] = 1'b1;
                    grant_s[vi_s]           = 1'b1;
                    rr_nxt_s[d]             = VC_W'((vi_s + 1) % NUM_VC);
                end else begin
                    found_s[d] = found_s[d];
                end
            end
        end
    end

    // Next ownership: drop released columns, add this cycle's winners
    always_comb begin
        claim_nxt_s = claim_r;
        busy_nxt_s  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            for (int d = 0; d < NUM_DIR; d++) begin
                if (release_dir[d]) begin
                    claim_nxt_s[v*NUM_DIR + d] = 1'b0;
                end else begin
                    claim_nxt_s[v*NUM_DIR + d] = claim_nxt_s[v*NUM_DIR + d];
                end
            end
        end
        claim_nxt_s = claim_nxt_s | win_s;
        for (int v = 0; v < NUM_VC; v++) begin
            busy_nxt_s = busy_nxt_s | claim_nxt_s[v*NUM_DIR +: NUM_DIR];
        end
    end

    // State and output registers; reset drops all ownership at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            claim_r <= '0;
            busy_r  <= '0;
            grant_r <= '0;
            bad_r   <= 1'b0;
            for (int d = 0; d < NUM_DIR; d++) begin
                rr_ptr_r[d] <= '0;
            end
        end else begin
            claim_r <= claim_nxt_s;
            busy_r  <= busy_nxt_s;
            grant_r <= grant_s;
            bad_r   <= bad_s;
            for (int d = 0; d < NUM_DIR; d++) begin
                rr_ptr_r[d] <= rr_nxt_s[d];
            end
        end
    end

    assign grant    = grant_r;
    assign claim    = claim_r;
    assign dir_busy = busy_r;
    assign bad_dir  = bad_r;

    vc_dir_alloc_chk #(.NUM_VC(NUM_VC), .NUM_DIR(NUM_DIR)) u_chk (
        .clock    (clock),
        .reset_n  (reset_n),
        .claim    (claim_r),
        .dir_busy (busy_r)
    );
endmodule

// File: tb/tb_vc_dir_alloc.sv
// Bench for vc_dir_alloc: directed vector table, hand-written corner
// sequences, and random traffic checked against an owner-list model.

module tb_vc_dir_alloc;
    localparam int NV = 4;
    localparam int ND = 12;
    localparam int DW = 4;

    logic              clock;
    logic              reset_n;
    logic [NV-1:0]     req_vc;
    logic [NV*DW-1:0]  req_dir;
    logic [ND-1:0]     release_dir;
    logic [NV-1:0]     grant;
    logic [NV*ND-1:0]  claim;
    logic [ND-1:0]     dir_busy;
    logic              bad_dir;

    int total = 0;
    int bad   = 0;

    // Model state: owner of each direction (-1 = free) and round-robin start
    int            owner [ND];
    int            rr    [ND];
    logic [NV-1:0] m_grant;
    logic          m_bad;

    typedef struct {
        logic [NV-1:0]    rv;
        logic [NV*DW-1:0] rd;
        logic [ND-1:0]    rel;
        logic [NV-1:0]    g;
        logic [ND-1:0]    busy;
        logic             b;
    } vec_t;
    vec_t vecs[13];

    vc_dir_alloc #(.NUM_VC(NV), .NUM_DIR(ND), .DIR_W(DW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_vc      (req_vc),
        .req_dir     (req_dir),
        .release_dir (release_dir),
        .grant       (grant),
        .claim       (claim),
        .dir_busy    (dir_busy),
        .bad_dir     (bad_dir)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            owner[d] = -1;
            rr[d]    = 0;
        end
        m_grant = '0;
        m_bad   = 1'b0;
    endtask

    function automatic logic [NV*ND-1:0] m_claim();
        logic [NV*ND-1:0] c = '0;
        for (int d = 0; d < ND; d++)
            if (owner[d] >= 0) c[owner[d]*ND + d] = 1'b1;
        return c;
    endfunction

    function automatic logic [ND-1:0] m_busy();
        logic [ND-1:0] b = '0;
        for (int d = 0; d < ND; d++) b[d] = (owner[d] >= 0);
        return b;
    endfunction

    // One clock edge of the allocator, described as owner-list bookkeeping
    task automatic model_step(input logic [NV-1:0] rv, input logic [NV*DW-1:0] rd,
                              input logic [ND-1:0] rel);
        int  nxt [ND];
        bit  holds [NV];
        int  want [NV];
        for (int v = 0; v < NV; v++) begin
            holds[v] = 0;
            want[v]  = int'(rd[v*DW +: DW]);
        end
        for (int d = 0; d < ND; d++) if (owner[d] >= 0) holds[owner[d]] = 1;
        m_grant = '0;
        m_bad   = 1'b0;
        for (int v = 0; v < NV; v++)
            if (rv[v] && !holds[v] && want[v] >= ND) m_bad = 1'b1;
        for (int d = 0; d < ND; d++) nxt[d] = rel[d] ? -1 : owner[d];
        for (int d = 0; d < ND; d++) begin
            if (owner[d] < 0) begin
                for (int k = 0; k < NV; k++) begin
                    int v = (rr[d] + k) % NV;
                    if (rv[v] && !holds[v] && want[v] == d) begin
                        nxt[d]     = v;
                        m_grant[v] = 1'b1;
                        rr[d]      = (v + 1) % NV;
                        break;
                    end
                end
            end
        end
        for (int d = 0; d < ND; d++) owner[d] = nxt[d];
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later
    task automatic cycle(input logic [NV-1:0] rv, input logic [NV*DW-1:0] rd,
                         input logic [ND-1:0] rel);
        req_vc      = rv;
        req_dir     = rd;
        release_dir = rel;
        @(posedge clock);
        model_step(rv, rd, rel);
        #1;
        check("grant", 64'(grant), 64'(m_grant));
        check("claim", 64'(claim), 64'(m_claim()));
        check("dir_busy", 64'(dir_busy), 64'(m_busy()));
        check("bad_dir", 64'(bad_dir), 64'(m_bad));
    endtask

    initial begin
        logic [NV-1:0]    rv;
        logic [NV*DW-1:0] rd;
        logic [ND-1:0]    rel;

        // rv, rd, rel, expected grant, expected dir_busy, expected bad_dir
        vecs[0]  = '{4'b0100, 16'h0500, 12'h000, 4'b0100, 12'h020, 1'b0}; // VC2 -> dir5
        vecs[1]  = '{4'b0000, 16'h0000, 12'h000, 4'b0000, 12'h020, 1'b0}; // grant drops
        vecs[2]  = '{4'b0000, 16'h0000, 12'h020, 4'b0000, 12'h000, 1'b0};
        vecs[3]  = '{4'b1111, 16'h3B10, 12'h000, 4'b1111, 12'h80B, 1'b0}; // 0,1,11,3
        vecs[4]  = '{4'b0000, 16'h0000, 12'h80B, 4'b0000, 12'h000, 1'b0}; // multi release
        vecs[5]  = '{4'b0010, 16'h00C0, 12'h000, 4'b0000, 12'h000, 1'b1}; // VC1 -> dir12
        vecs[6]  = '{4'b0000, 16'h0000, 12'h000, 4'b0000, 12'h000, 1'b0};
        vecs[7]  = '{4'b0010, 16'h0040, 12'h000, 4'b0010, 12'h010, 1'b0}; // VC1 -> dir4
        vecs[8]  = '{4'b1000, 16'h4000, 12'h010, 4'b0000, 12'h000, 1'b0}; // collision
        vecs[9]  = '{4'b1000, 16'h4000, 12'h000, 4'b1000, 12'h010, 1'b0}; // VC3 wins next
        vecs[10] = '{4'b0001, 16'h0002, 12'h000, 4'b0001, 12'h014, 1'b0}; // VC0 -> dir2
        vecs[11] = '{4'b1001, 16'h4002, 12'h000, 4'b0000, 12'h014, 1'b0}; // owners ignored
        vecs[12] = '{4'b0000, 16'h0000, 12'h014, 4'b0000, 12'h000, 1'b0};

        reset_n     = 1'b0;
        req_vc      = '0;
        req_dir     = '0;
        release_dir = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_claim", 64'(claim), 64'd0);
        check("reset_busy", 64'(dir_busy), 64'd0);
        check("reset_bad", 64'(bad_dir), 64'd0);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rv, vecs[i].rd, vecs[i].rel);
            check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].g));
            check($sformatf("vec%0d_busy", i), 64'(dir_busy), 64'(vecs[i].busy));
            check($sformatf("vec%0d_bad", i), 64'(bad_dir), 64'(vecs[i].b));
        end
        check("vec_claim_vc2_dir5_gone", 64'(claim[2*ND+5]), 64'd0);

        // Round-robin on dir7: every VC keeps asking; owner releases a cycle after its grant
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 16'h7777, 12'h000);
            check($sformatf("rr_grant%0d", i), 64'(grant), 64'(4'b0001 << (i % 4)));
            cycle(4'b1111, 16'h7777, 12'h080);
            check($sformatf("rr_gap%0d", i), 64'(grant), 64'd0);
        end
        // Pointer for dir7 must now start at VC1
        cycle(4'b1111, 16'h7777, 12'h000);
        check("rr_ptr_after", 64'(grant), 64'(4'b0010));
        cycle(4'b0000, 16'h0000, 12'h080);

        // Asynchronous reset with three directions owned
        cycle(4'b0111, 16'h0210, 12'h000);
        check("pre_reset_busy", 64'(dir_busy), 64'(12'h007));
        reset_n = 1'b0;
        #1;
        check("async_grant", 64'(grant), 64'd0);
        check("async_claim", 64'(claim), 64'd0);
        check("async_busy", 64'(dir_busy), 64'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        // Ownership is gone without any release pulse
        cycle(4'b0001, 16'h0001, 12'h000);
        check("post_reset_regrant", 64'(grant), 64'(4'b0001));

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rv  = NV'($urandom);
            rel = ND'($urandom) & ND'($urandom) & ND'($urandom);
            for (int v = 0; v < NV; v++) rd[v*DW +: DW] = DW'($urandom_range(0, 13));
            cycle(rv, rd, rel);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
